// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 512x32 RAM between the fetch (f_*) and load/store
// (d_*) requesters. Each grant runs a fixed WAIT_CYCLES-long strobe window,
// followed by a single-cycle ack with registered read data. Ties go to the
// requester that did not win last time.
//
// Handshake: a requester raises req with we/addr/wdata valid and keeps req
// high until it sees its ack pulse. Requests are sampled only in IDLE, and
// the inputs are captured at the grant edge, so they may change afterwards.
// ack is high for exactly one cycle, and rdata is valid during it. req must
// be low by the IDLE cycle after ack, or it counts as a new request.
module mem_arbiter #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              f_req,
  input  logic              f_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  counter;
  // last_f is 1 while fetch owns the current/most recent grant, 0 for data.
  logic              last_f;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_f;
  logic              grant_d;
  logic              last_beat;

  // Next-state and grant decision; ties go to the port that did not win last.
  always_comb begin
    state_nxt = state;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    last_beat = (counter == CNT_LAST);
    case (state)
      IDLE: begin
        if (f_req && (!d_req || !last_f)) begin
          grant_f = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_f || grant_d) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request capture, beat counter and registered read data.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      counter <= '0;
      last_f  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant_f) begin
        last_f  <= 1'b1;
        we_q    <= f_we;
        addr_q  <= f_addr;
        wdata_q <= f_wdata;
        counter <= '0;
      end else if (grant_d) begin
        last_f  <= 1'b0;
        we_q    <= d_we;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        counter <= '0;
      end
      if (state == ACCESS) begin
        counter <= counter + CNT_W'(1);
        if (last_beat && !we_q) begin
          if (last_f) begin
            f_rdata <= ram_rdata;
          end else begin
            d_rdata <= ram_rdata;
          end
        end
      end
    end
  end

  // RAM strobes only in ACCESS; the bus is zeroed otherwise so Mdatain floats.
  always_comb begin
    ram_read    = (state == ACCESS) && !we_q;
    ram_write   = (state == ACCESS) && we_q;
    ram_address = (state == ACCESS) ? addr_q  : '0;
    ram_wdata   = (state == ACCESS) ? wdata_q : '0;
    f_ack       = (state == DONE) && last_f;
    d_ack       = (state == DONE) && !last_f;
    busy        = (state != IDLE);
    dbg_state   = state;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed traffic on both requesters of
// mem_arbiter, with a behavioural RAM. A transaction-level reference model
// predicts each grant, and a queue-based scoreboard checks the acks, the read
// data and the RAM bus.
module tb_mem_arbiter;

  localparam int W = 1;

  logic        clock;
  logic        clear;
  logic        f_req, f_we, d_req, d_we;
  logic [8:0]  f_addr, d_addr;
  logic [31:0] f_wdata, d_wdata, f_rdata, d_rdata;
  logic        f_ack, d_ack;
  logic        ram_read, ram_write, busy;
  logic [8:0]  ram_address;
  logic [31:0] ram_wdata, ram_rdata;
  logic [1:0]  dbg_state;

  // Second instance with a 3-cycle strobe window.
  logic        w3_f_req, w3_f_ack, w3_d_ack, w3_ram_read, w3_ram_write, w3_busy;
  logic [8:0]  w3_f_addr, w3_ram_address;
  logic [31:0] w3_f_rdata, w3_d_rdata, w3_ram_wdata, w3_ram_rdata;
  logic [1:0]  w3_dbg_state;

  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state.
  int          m_left = 0;
  bit          m_rst = 1'b0;
  bit          m_last_f = 1'b0;
  logic        m_we = 1'b0;
  logic [8:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_f_held = '0;
  logic [31:0] m_d_held = '0;

  // Scoreboard.
  logic [31:0] f_exp_q[$];
  logic [31:0] d_exp_q[$];
  int          f_cyc_q[$];
  int          d_cyc_q[$];
  logic [31:0] f_shown = '0;
  logic [31:0] d_shown = '0;
  bit          ack_seq[$];

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clock(clock), .clear(clear),
    .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_rdata(f_rdata), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) u_w3 (
    .clock(clock), .clear(clear),
    .f_req(w3_f_req), .f_we(1'b0), .f_addr(w3_f_addr), .f_wdata(32'd0),
    .f_rdata(w3_f_rdata), .f_ack(w3_f_ack),
    .d_req(1'b0), .d_we(1'b0), .d_addr(9'd0), .d_wdata(32'd0),
    .d_rdata(w3_d_rdata), .d_ack(w3_d_ack),
    .ram_read(w3_ram_read), .ram_write(w3_ram_write),
    .ram_address(w3_ram_address), .ram_wdata(w3_ram_wdata),
    .ram_rdata(w3_ram_rdata), .busy(w3_busy), .dbg_state(w3_dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Behavioural RAM; the real part floats Mdatain when not reading.
  assign ram_rdata    = ram_read ? mem[ram_address] : '0;
  assign w3_ram_rdata = w3_ram_read ? (32'hC0DE0000 | {23'd0, w3_ram_address}) : '0;

  always @(posedge clock) begin
    if (ram_write) mem[ram_address] = ram_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: at every rising edge, a free arbiter grants one pending
  // request (round-robin on ties) and is then occupied for W strobe cycles
  // plus one ack cycle. The expected response is queued at grant time.
  initial begin
    bit gf, gd;
    forever begin
      @(posedge clock);
      cyc++;
      if (clear) begin
        m_rst = 1'b1;
        m_left = 0;
        m_last_f = 1'b0;
        m_f_held = '0;
        m_d_held = '0;
        f_exp_q.delete(); f_cyc_q.delete();
        d_exp_q.delete(); d_cyc_q.delete();
      end else begin
        m_rst = 1'b0;
        if (m_left == 0) begin
          gf = f_req && (!d_req || !m_last_f);
          gd = d_req && !gf;
          if (gf || gd) begin
            m_last_f = gf;
            m_we    = gf ? f_we    : d_we;
            m_addr  = gf ? f_addr  : d_addr;
            m_wdata = gf ? f_wdata : d_wdata;
            if (m_we) ref_mem[m_addr] = m_wdata;
            else if (gf) m_f_held = ref_mem[m_addr];
            else m_d_held = ref_mem[m_addr];
            if (gf) begin
              f_exp_q.push_back(m_f_held);
              f_cyc_q.push_back(cyc + W);
            end else begin
              d_exp_q.push_back(m_d_held);
              d_cyc_q.push_back(cyc + W);
            end
            m_left = W + 1;
          end
        end else begin
          m_left--;
        end
      end
    end
  end

  // Monitor: checks the RAM bus every cycle and pops the scoreboard on acks.
  initial begin
    logic [43:0] exp_bus, act_bus;
    bit          acc;
    forever begin
      @(negedge clock);
      if (m_rst) begin
        f_shown = '0;
        d_shown = '0;
        check("reset_rdata", {f_rdata, d_rdata}, 64'd0);
        check("reset_acks", {f_ack, d_ack}, 2'b00);
      end
      acc = (m_left >= 2);
      exp_bus = {m_left != 0, acc && !m_we, acc && m_we,
                 acc ? m_addr : 9'd0, acc ? m_wdata : 32'd0};
      act_bus = {busy, ram_read, ram_write, ram_address, ram_wdata};
      check("ram_bus", act_bus, exp_bus);
      check("dual_ack", f_ack & d_ack, 1'b0);
      if (f_ack) begin
        ack_seq.push_back(1'b1);
        if (f_exp_q.size() == 0) begin
          check("f_ack_spurious", f_ack, 1'b0);
        end else begin
          check("f_ack_cycle", cyc, f_cyc_q.pop_front());
          f_shown = f_exp_q.pop_front();
          check("f_rdata", f_rdata, f_shown);
          check("d_rdata_hold", d_rdata, d_shown);
        end
      end
      if (d_ack) begin
        ack_seq.push_back(1'b0);
        if (d_exp_q.size() == 0) begin
          check("d_ack_spurious", d_ack, 1'b0);
        end else begin
          check("d_ack_cycle", cyc, d_cyc_q.pop_front());
          d_shown = d_exp_q.pop_front();
          check("d_rdata", d_rdata, d_shown);
          check("f_rdata_hold", f_rdata, f_shown);
        end
      end
      if (f_cyc_q.size() != 0 && f_cyc_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL f_ack_missing: got no ack expected ack in cycle %0d", f_cyc_q[0]);
        void'(f_cyc_q.pop_front()); void'(f_exp_q.pop_front());
      end
      if (d_cyc_q.size() != 0 && d_cyc_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL d_ack_missing: got no ack expected ack in cycle %0d", d_cyc_q[0]);
        void'(d_cyc_q.pop_front()); void'(d_exp_q.pop_front());
      end
    end
  end

  // Driver: one request on port f (pf=1) or d; holds req until ack.
  // mutate scrambles the inputs while the arbiter is busy; drop releases req
  // once busy is seen (only used when the grant is known to be ours).
  task automatic req_access(input bit pf, input logic we, input logic [8:0] addr,
                            input logic [31:0] wdata, input bit mutate, input bit drop);
    int n;
    bit done;
    @(negedge clock);
    if (pf) begin f_req = 1'b1; f_we = we; f_addr = addr; f_wdata = wdata; end
    else    begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    done = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
      if (pf ? f_ack : d_ack) begin
        if (pf) f_req = 1'b0; else d_req = 1'b0;
        done = 1'b1;
      end else if (busy) begin
        if (mutate) begin
          if (pf) begin
            f_we = 1'($urandom_range(0, 1)); f_addr = 9'($urandom_range(0, 511)); f_wdata = $urandom;
          end else begin
            d_we = 1'($urandom_range(0, 1)); d_addr = 9'($urandom_range(0, 511)); d_wdata = $urandom;
          end
        end
        if (drop) begin
          if (pf) f_req = 1'b0; else d_req = 1'b0;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no ack expected ack within 40 cycles", pf ? "f" : "d");
      if (pf) f_req = 1'b0; else d_req = 1'b0;
    end
  endtask

  task automatic random_port(input bit pf, input int count);
    logic [8:0] a;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      a = ($urandom_range(0, 9) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
      req_access(pf, 1'($urandom_range(0, 2) == 0), a, $urandom,
                 $urandom_range(0, 3) == 0, 1'b0);
    end
  endtask

  // Main sequence.
  initial begin
    logic [31:0] v;
    logic [7:0]  seq_v, rd_mask, ack_mask, dack_mask;
    logic [31:0] w3_got;
    bit          saw_ack;
    for (int i = 0; i < 512; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    clear = 1'b1;
    f_req = 0; f_we = 0; f_addr = '0; f_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    w3_f_req = 0; w3_f_addr = '0;
    repeat (3) @(negedge clock);
    check("rst_strobes", {busy, ram_read, ram_write, f_ack, d_ack, ram_address}, 64'd0);
    check("rst_w3_idle", {w3_busy, w3_ram_read, w3_f_ack}, 3'b000);
    clear = 1'b0;

    // Single fetch read.
    req_access(1'b1, 1'b0, 9'h010, 32'd0, 1'b0, 1'b0);
    check("fetch_read_deadbeef", f_rdata, 32'hDEADBEEF);

    // Store then load at the top address.
    req_access(1'b0, 1'b1, 9'h1FF, 32'h12345678, 1'b0, 1'b0);
    req_access(1'b0, 1'b0, 9'h1FF, 32'd0, 1'b0, 1'b0);
    check("load_after_store", d_rdata, 32'h12345678);
    check("f_rdata_kept", f_rdata, 32'hDEADBEEF);

    // Data request arriving while a fetch is in flight; fetch inputs change.
    fork
      req_access(1'b1, 1'b0, 9'h0A0, 32'd0, 1'b1, 1'b1);
      begin
        @(negedge clock);
        req_access(1'b0, 1'b0, 9'h0A1, 32'd0, 1'b0, 1'b0);
      end
    join
    f_we = 1'b0;

    // Both requesters held high out of reset: grants must alternate F, D.
    @(negedge clock);
    clear = 1'b1;
    f_req = 1; f_we = 0; f_addr = 9'h020;
    d_req = 1; d_we = 0; d_addr = 9'h021;
    repeat (2) @(negedge clock);
    ack_seq.delete();
    clear = 1'b0;
    fork
      for (int i = 0; i < 4; i++) req_access(1'b1, 1'b0, 9'h020, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) req_access(1'b0, 1'b0, 9'h021, 32'd0, 1'b0, 1'b0);
    join
    seq_v = '0;
    for (int i = 0; i < 8 && i < ack_seq.size(); i++) seq_v[7-i] = ack_seq[i];
    check("alt_count", ack_seq.size(), 8);
    check("alt_order", seq_v, 8'b10101010);

    // Reset in the middle of a store.
    @(negedge clock);
    d_req = 1; d_we = 1; d_addr = 9'h055; d_wdata = 32'hA5A55A5A;
    @(negedge clock);
    check("mid_busy", busy, 1'b1);
    clear = 1'b1;
    d_req = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    check("rst_mid_strobes", {ram_read, ram_write, busy}, 3'b000);
    saw_ack = 1'b0;
    repeat (4) begin
      @(negedge clock);
      saw_ack = saw_ack | d_ack;
    end
    check("rst_mid_no_ack", saw_ack, 1'b0);
    check("rst_mid_rdata", {f_rdata, d_rdata}, 64'd0);

    // Random traffic on both ports.
    fork
      random_port(1'b1, 60);
      random_port(1'b0, 60);
    join
    repeat (6) @(negedge clock);
    check("f_queue_drained", f_exp_q.size(), 0);
    check("d_queue_drained", d_exp_q.size(), 0);

    // WAIT_CYCLES=3 instance: one read.
    w3_f_req = 1'b1;
    w3_f_addr = 9'h0AB;
    rd_mask = '0; ack_mask = '0; dack_mask = '0; w3_got = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      rd_mask[k] = w3_ram_read;
      ack_mask[k] = w3_f_ack;
      dack_mask[k] = w3_d_ack;
      if (w3_f_ack) begin
        w3_f_req = 1'b0;
        w3_got = w3_f_rdata;
      end
    end
    check("w3_read_window", rd_mask, 8'b0000_0111);
    check("w3_ack_cycle", ack_mask, 8'b0000_1000);
    check("w3_rdata", w3_got, 32'hC0DE00AB);
    check("w3_no_d_ack", dack_mask, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
